// File: rtl/fp_pkg.sv
// Shared FP datapath definitions: per-format widths, lane field positions and
// the S1 flag bundle carried by the post-add/sub normaliser pipeline.
package fp_pkg;

    localparam int HP_MANT_W  = 11;
    localparam int HP_EXP_W   = 6;
    localparam int HP_EXP_INF = 31;

    localparam int SP_MANT_W  = 24;
    localparam int SP_EXP_W   = 9;
    localparam int SP_EXP_INF = 255;

    localparam int DP_MANT_W  = 53;
    localparam int DP_EXP_W   = 12;
    localparam int DP_EXP_INF = 2047;

    // HEAD_BIT/MANT_HI are the single-precision lane positions; the low fields
    // sit at the same index for every format.
    localparam int HEAD_BIT = SP_MANT_W + 2;
    localparam int MANT_HI  = SP_MANT_W + 1;
    localparam int MANT_LO  = 2;
    localparam int G_BIT    = 1;
    localparam int R_BIT    = 0;

    typedef enum logic {
        PATH_ADD = 1'b0,
        PATH_SUB = 1'b1
    } path_e;

    typedef struct packed {
        path_e add_sub;
        logic  sticky;
        logic  zero;
        logic  ovf_shift;
    } s1_flags_t;

endpackage

// File: rtl/lzc_n.sv
// Leading-zero counter over an N-bit vector; an all-zero input returns N.
module lzc_n #(
    parameter int N = 26
) (
    input  logic [N-1:0]             i_vec,
    output logic [$clog2(N+1)-1:0]   o_cnt
);

    localparam int CNT_W = $clog2(N + 1);

    // Scanning upward lets the highest set bit win the final assignment.
    always_comb begin
        o_cnt = CNT_W'(N);
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                o_cnt = CNT_W'(N - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage post-add/sub normaliser: S1 registers the lane with its leading-zero
// count, S2 shifts, adjusts and clamps the exponent behind a valid/ready handshake.
module fp_normalize_pipe
    import fp_pkg::*;
#(
    parameter  int MANT_W  = SP_MANT_W,
    parameter  int EXP_W   = SP_EXP_W,
    parameter  int EXP_INF = SP_EXP_INF,
    localparam int LANE_W  = MANT_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_lane,
    input  logic              in_add_sub,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sticky,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_g,
    output logic              out_r,
    output logic              out_sticky,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_is_zero,
    output logic              out_subnormal,
    output logic              out_ovf
);

    localparam int L_HEAD    = LANE_W - 1;
    localparam int L_MANT_HI = LANE_W - 2;
    localparam int LZC_N     = LANE_W - 1;
    localparam int LZC_W     = $clog2(LZC_N + 1);
    localparam int CMP_W     = (EXP_W > LZC_W) ? EXP_W : LZC_W;

    typedef struct packed {
        logic [LANE_W-1:0] lane;
        logic [EXP_W-1:0]  exp;
        logic [LZC_W-1:0]  lzc;
        s1_flags_t         f;
    } s1_reg_t;

    logic [LZC_W-1:0] w_lzc;
    logic             w_adv2;
    logic             r_s1_valid;
    logic             r_s2_valid;
    s1_reg_t          r_s1;

    lzc_n #(.N(LZC_N)) u_lzc (
        .i_vec (in_lane[L_MANT_HI:0]),
        .o_cnt (w_lzc)
    );

    assign w_adv2    = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !rst && (!r_s1_valid || w_adv2);
    assign out_valid = r_s2_valid;

    // NOTE: state registers use non-blocking assignments so every always_ff
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
        end
    end

    // NOTE: the S1 payload carries no reset; it is only observed behind r_s1_valid.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            r_s1.lane        <= in_lane;
            r_s1.exp         <= in_exp;
            r_s1.lzc         <= w_lzc;
            r_s1.f.add_sub   <= path_e'(in_add_sub);
            r_s1.f.sticky    <= in_sticky;
            r_s1.f.zero      <= (in_lane == '0);
            r_s1.f.ovf_shift <= in_lane[L_HEAD];
        end
    end

    logic [L_MANT_HI:0] w_lane_n;
    logic [EXP_W-1:0]   w_exp_n;
    logic [EXP_W-1:0]   w_limit;
    logic [CMP_W-1:0]   w_lzc_c;
    logic [CMP_W-1:0]   w_lim_c;
    logic [LZC_W-1:0]   w_shift;
    logic               w_sticky_n;
    logic               w_sub_n;
    logic               w_ovf_n;

    // NOTE: every always_comb target gets a default first so no branch can infer a latch.
    always_comb begin
        w_lane_n   = r_s1.lane[L_MANT_HI:0];
        w_exp_n    = r_s1.exp;
        w_sticky_n = r_s1.f.sticky;
        w_sub_n    = 1'b0;
        w_ovf_n    = 1'b0;
        w_limit    = (r_s1.exp == '0) ? '0 : r_s1.exp - EXP_W'(1);
        w_lzc_c    = CMP_W'(r_s1.lzc);
        w_lim_c    = CMP_W'(w_limit);
        w_shift    = (w_lzc_c < w_lim_c) ? r_s1.lzc : LZC_W'(w_lim_c);

        if (r_s1.f.zero) begin
            w_lane_n = '0;
            w_exp_n  = '0;
        end else if (r_s1.f.add_sub == PATH_ADD) begin
            if (r_s1.f.ovf_shift) begin
                w_lane_n   = r_s1.lane[L_HEAD:1];
                w_exp_n    = r_s1.exp + EXP_W'(1);
                w_sticky_n = r_s1.f.sticky | r_s1.lane[0];
            end
            // The rounder turns this into inf; the exponent is left unsaturated.
            w_ovf_n = (w_exp_n >= EXP_W'(EXP_INF));
        end else begin
            // The headroom bit is shifted out by any non-zero shift, so only the
            // lower lane bits take part.
            w_lane_n = r_s1.lane[L_MANT_HI:0] << w_shift;
            w_exp_n  = r_s1.exp - EXP_W'(w_shift);
            w_sub_n  = !w_lane_n[L_MANT_HI];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid    <= 1'b0;
            out_mant      <= '0;
            out_g         <= 1'b0;
            out_r         <= 1'b0;
            out_sticky    <= 1'b0;
            out_exp       <= '0;
            out_is_zero   <= 1'b0;
            out_subnormal <= 1'b0;
            out_ovf       <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid    <= 1'b1;
            out_mant      <= w_lane_n[L_MANT_HI:MANT_LO];
            out_g         <= w_lane_n[G_BIT];
            out_r         <= w_lane_n[R_BIT];
            out_sticky    <= w_sticky_n;
            out_exp       <= w_exp_n;
            out_is_zero   <= r_s1.f.zero;
            out_subnormal <= w_sub_n;
            out_ovf       <= w_ovf_n;
        end else if (out_ready) begin
            r_s2_valid    <= 1'b0;
        end
    end

endmodule
